// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: multiply/divide op codes,
// sequencer states and the main-control stall state used while the sequencer is busy.
package mips_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // Main control: R-type execute pulses Start, then parks in the stall state until Done.
  localparam logic [3:0] CTRL_EXEC_R   = 4'd6;
  localparam logic [3:0] CTRL_MD_STALL = 4'd12;

endpackage

// File: rtl/md_negate.sv
// Combinational two's-complement negate of a W-bit value.
module md_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = ~din + W'(1);

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Sign handling is done on magnitudes: abs on entry, sign fix-up in one extra cycle.
import mips_pkg::*;

module mult_div_ctrl #(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic               sign_res;
  logic               sign_a;
  logic               is_div;
  logic               div_zero_pend;

  logic [WIDTH-1:0]   neg_a, neg_b, a_mag, b_mag;
  logic [2*WIDTH-1:0] neg_prod;
  logic [WIDTH-1:0]   neg_quot, neg_rem;

  md_negate #(.W(WIDTH))   u_neg_a    (.din(A),                   .dout(neg_a));
  md_negate #(.W(WIDTH))   u_neg_b    (.din(B),                   .dout(neg_b));
  md_negate #(.W(2*WIDTH)) u_neg_prod (.din(acc),                 .dout(neg_prod));
  md_negate #(.W(WIDTH))   u_neg_quot (.din(acc[WIDTH-1:0]),      .dout(neg_quot));
  md_negate #(.W(WIDTH))   u_neg_rem  (.din(acc[2*WIDTH-1:WIDTH]), .dout(neg_rem));

  assign a_mag = (!Op[0] && A[WIDTH-1]) ? neg_a : A;
  assign b_mag = (!Op[0] && B[WIDTH-1]) ? neg_b : B;

  // Multiply step: conditional add into the upper half, carry kept in the shift.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, mcand} & {(WIDTH+1){acc[0]}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: restoring; rem shifted left may need WIDTH+1 bits before the trial subtract.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = {1'b0, rem_sh} - {2'b00, mcand};
  assign div_next = div_diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= MD_IDLE;
      cnt           <= '0;
      acc           <= '0;
      mcand         <= '0;
      sign_res      <= 1'b0;
      sign_a        <= 1'b0;
      is_div        <= 1'b0;
      div_zero_pend <= 1'b0;
      Hi            <= '0;
      Lo            <= '0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      DivZero       <= 1'b0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (Start) begin
            if (Op[1] && (B == '0)) begin
              div_zero_pend <= 1'b1;
              state         <= MD_DONE;
            end else begin
              is_div   <= Op[1];
              sign_res <= !Op[0] && (A[WIDTH-1] ^ B[WIDTH-1]);
              sign_a   <= !Op[0] && A[WIDTH-1];
              // Multiply: multiplier in acc low, multiplicand aside. Divide: dividend in quot, divisor aside.
              acc      <= Op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              mcand    <= Op[1] ? b_mag : a_mag;
              cnt      <= '0;
              state    <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          Busy <= 1'b1;
          acc  <= is_div ? div_next : mul_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1))
            state <= MD_FIX;
        end
        MD_FIX: begin
          if (is_div) begin
            Lo <= sign_res ? neg_quot : acc[WIDTH-1:0];
            Hi <= sign_a   ? neg_rem  : acc[2*WIDTH-1:WIDTH];
          end else begin
            {Hi, Lo} <= sign_res ? neg_prod : acc;
          end
          state <= MD_DONE;
        end
        MD_DONE: begin
          Done          <= 1'b1;
          DivZero       <= div_zero_pend;
          div_zero_pend <= 1'b0;
          Busy          <= 1'b0;
          state         <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: results, latency, divide-by-zero, ignored restart, mid-op reset.
module tb_mult_div_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int n_tests = 0;
  int n_fail  = 0;
  int lat, busy_n, dones;
  logic dz;

  always #5 Clock = ~Clock;

  mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start is high for exactly the acceptance edge; cycles counted from that edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int restart_at,
                        output int lat_o, output int busy_o, output logic dz_o);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    lat_o = -1; busy_o = 0; dz_o = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == restart_at) begin
        Start = 1'b1;
        A = 32'd1000;
      end
      @(posedge Clock); #1;
      Start = 1'b0;
      if (Busy) busy_o++;
      if (Done) begin
        lat_o = c;
        dz_o  = DivZero;
        break;
      end
    end
  endtask

  task automatic count_dones(input int n, output int d);
    d = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge Clock); #1;
      if (Done) d++;
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_hi",   {32'd0, Hi}, 64'd0);
    chk("rst_lo",   {32'd0, Lo}, 64'd0);
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_dz",   {63'd0, DivZero}, 64'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, busy_n, dz);
    chk("multu_lat",  lat, 34);
    chk("multu_busy", busy_n, 33);
    chk("multu_dz",   {63'd0, dz}, 64'd0);
    chk("multu_hi",   {32'd0, Hi}, 64'hFFFF_FFFE);
    chk("multu_lo",   {32'd0, Lo}, 64'h0000_0001);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, lat, busy_n, dz);
    chk("mult_neg_lat", lat, 34);
    chk("mult_neg_hi",  {32'd0, Hi}, 64'hFFFF_FFFF);
    chk("mult_neg_lo",  {32'd0, Lo}, 64'hFFFF_FFEB);

    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, lat, busy_n, dz);
    chk("mult_min_hi", {32'd0, Hi}, 64'h4000_0000);
    chk("mult_min_lo", {32'd0, Lo}, 64'h0);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, lat, busy_n, dz);
    chk("div_neg_lat", lat, 34);
    chk("div_neg_lo",  {32'd0, Lo}, 64'hFFFF_FFFD);
    chk("div_neg_hi",  {32'd0, Hi}, 64'hFFFF_FFFF);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, busy_n, dz);
    chk("div_ovf_lo", {32'd0, Lo}, 64'h8000_0000);
    chk("div_ovf_hi", {32'd0, Hi}, 64'h0);

    run_op(2'b11, 32'd100, 32'd7, 0, lat, busy_n, dz);
    chk("divu_lat", lat, 34);
    chk("divu_lo",  {32'd0, Lo}, 64'd14);
    chk("divu_hi",  {32'd0, Hi}, 64'd2);

    run_op(2'b11, 32'd5, 32'd0, 0, lat, busy_n, dz);
    chk("dz_lat",  lat, 1);
    chk("dz_flag", {63'd0, dz}, 64'd1);
    chk("dz_busy", busy_n, 0);
    chk("dz_hi",   {32'd0, Hi}, 64'd2);
    chk("dz_lo",   {32'd0, Lo}, 64'd14);

    run_op(2'b01, 32'd5, 32'd6, 10, lat, busy_n, dz);
    chk("restart_lat", lat, 34);
    chk("restart_lo",  {32'd0, Lo}, 64'd30);
    chk("restart_hi",  {32'd0, Hi}, 64'd0);
    count_dones(40, dones);
    chk("restart_single_done", dones, 0);

    Op = 2'b10; A = 32'hFFFF_FFF9; B = 32'd2; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (19) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk("abort_done", {63'd0, Done}, 64'd0);
    chk("abort_hi",   {32'd0, Hi}, 64'd0);
    chk("abort_lo",   {32'd0, Lo}, 64'd0);
    count_dones(40, dones);
    chk("abort_no_done", dones, 0);

    run_op(2'b01, 32'd3, 32'd4, 0, lat, busy_n, dz);
    chk("post_lat",  lat, 34);
    chk("post_busy", busy_n, 33);
    chk("post_lo",   {32'd0, Lo}, 64'd12);
    chk("post_hi",   {32'd0, Hi}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
